// File: rtl/cnn_pkg.sv
// Shared types and sizes for the CNN datapath stages.
// Image buffer is row-major, one signed pixel per entry.
package cnn_pkg;
  localparam int DATA_SIZE      = 16;
  localparam int IMG_SIZE_WIDTH = 16;
  localparam int BUF_DEPTH      = 1024;
  localparam int KERNEL_DIM     = 5;
  localparam int BLOCK_SIZE     = KERNEL_DIM * KERNEL_DIM;
  localparam int MAX_IMG        = 32;
  localparam int IDX_W          = 10;
  localparam int POS_W          = 5;
  localparam int SZ_W           = 6;

  typedef logic signed [DATA_SIZE-1:0] pixel_t;
  typedef pixel_t [BLOCK_SIZE-1:0] window_t;
  typedef pixel_t [BUF_DEPTH-1:0] image_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef idx_t [BLOCK_SIZE-1:0] idx_win_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LOAD,
    S_EMIT,
    S_FIN
  } win_state_t;

  function automatic logic size_ok(
    input logic [IMG_SIZE_WIDTH-1:0] s
  );
    return (s >= IMG_SIZE_WIDTH'(KERNEL_DIM))
        && (s <= IMG_SIZE_WIDTH'(MAX_IMG));
  endfunction
endpackage

// File: rtl/conv_window_index.sv
// Buffer addresses of a KERNEL_DIM x KERNEL_DIM window.
// Pure combinational; shared with the pooling window stage.
module conv_window_index
  import cnn_pkg::*;
(
  input  logic [POS_W-1:0] i_row,
  input  logic [POS_W-1:0] i_col,
  input  logic [SZ_W-1:0]  i_size,
  output idx_win_t         o_idx
);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < KERNEL_DIM; i++) begin
      for (int j = 0; j < KERNEL_DIM; j++) begin
        o_idx[i*KERNEL_DIM+j] =
          (IDX_W'(i_row) + IDX_W'(i)) * IDX_W'(i_size)
          + IDX_W'(i_col) + IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Walks the image with a 5x5 stride-1 window and hands each
// window to the MAC stage over a valid/ready handshake.
module conv_window_gen
  import cnn_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [IMG_SIZE_WIDTH-1:0] size,
  input  image_t                    img,
  output window_t                   win_out,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [POS_W-1:0]          out_row,
  output logic [POS_W-1:0]          out_col,
  output logic                      done,
  output logic                      err
);

  win_state_t              r_state;
  win_state_t              w_next;
  logic [IMG_SIZE_WIDTH-1:0] r_size;
  logic [POS_W-1:0]        r_last;
  logic [POS_W-1:0]        r_row;
  logic [POS_W-1:0]        r_col;
  logic [POS_W-1:0]        r_out_row;
  logic [POS_W-1:0]        r_out_col;
  logic                    r_bad;
  window_t                 r_win;
  idx_win_t                w_idx;
  logic                    w_size_ok;
  logic                    w_last_win;

  assign w_size_ok  = size_ok(r_size);
  assign w_last_win = (r_row == r_last) && (r_col == r_last);

  conv_window_index u_index (
    .i_row  (r_row),
    .i_col  (r_col),
    .i_size (r_size[SZ_W-1:0]),
    .o_idx  (w_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (enable) w_next = S_CHECK;
      S_CHECK: w_next = w_size_ok ? S_LOAD : S_FIN;
      S_LOAD:  w_next = S_EMIT;
      S_EMIT: begin
        if (win_ready)
          w_next = w_last_win ? S_FIN : S_LOAD;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_size    <= '0;
      r_last    <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_out_row <= '0;
      r_out_col <= '0;
      r_bad     <= 1'b0;
      r_win     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_size <= size;
            r_row  <= '0;
            r_col  <= '0;
            r_bad  <= 1'b0;
          end
        end
        S_CHECK: begin
          r_bad  <= !w_size_ok;
          r_last <= POS_W'(r_size - IMG_SIZE_WIDTH'(KERNEL_DIM));
        end
        S_LOAD: begin
          for (int k = 0; k < BLOCK_SIZE; k++)
            r_win[k] <= img[w_idx[k]];
          r_out_row <= r_row;
          r_out_col <= r_col;
        end
        S_EMIT: begin
          // Position advances on accept; the emitted copy stays put.
          if (win_ready) begin
            if (r_col != r_last) begin
              r_col <= r_col + 1'b1;
            end else if (r_row != r_last) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign win_out   = r_win;
  assign out_row   = r_out_row;
  assign out_col   = r_out_col;
  assign win_valid = (r_state == S_EMIT);
  assign done      = (r_state == S_FIN);
  assign err       = (r_state == S_FIN) && r_bad;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen.
// img[k] = k, so window pixels equal their buffer addresses.
module tb_conv_window_gen;
  import cnn_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] size;
  image_t      img;
  window_t     win_out;
  logic        win_valid;
  logic        win_ready;
  logic [4:0]  out_row;
  logic [4:0]  out_col;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  conv_window_gen dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .size      (size),
    .img       (img),
    .win_out   (win_out),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .out_row   (out_row),
    .out_col   (out_col),
    .done      (done),
    .err       (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input int sz);
    size   = 16'(sz);
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!win_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, win_valid}, 32'd1);
  endtask

  int    cyc, nwin, er, ec, bad_order, unstable, spur;
  logic [31:0] f0, f24;

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    win_ready = 1'b1;
    size      = '0;
    for (int k = 0; k < BUF_DEPTH; k++) img[k] = 16'(k);
    tick();
    tick();
    chk("rst_valid", {31'd0, win_valid}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_row", {27'd0, out_row}, 0);
    chk("rst_col", {27'd0, out_col}, 0);
    chk("rst_win", {31'd0, win_out == '0}, 1);
    rst = 1'b0;
    tick();

    // size 5: single window, first valid three cycles after enable
    start(5);
    chk("s5_c1_valid", {31'd0, win_valid}, 0);
    tick();
    chk("s5_c2_valid", {31'd0, win_valid}, 0);
    tick();
    chk("s5_c3_valid", {31'd0, win_valid}, 1);
    chk("s5_row", {27'd0, out_row}, 0);
    chk("s5_col", {27'd0, out_col}, 0);
    for (int k = 0; k < BLOCK_SIZE; k++)
      chk($sformatf("s5_pix%0d", k), 32'(win_out[k]), 32'(k));
    tick();
    chk("s5_done", {31'd0, done}, 1);
    chk("s5_err", {31'd0, err}, 0);
    chk("s5_fin_valid", {31'd0, win_valid}, 0);
    tick();
    chk("s5_done_clr", {31'd0, done}, 0);

    // size 6: four windows in raster order
    start(6);
    for (int w = 0; w < 4; w++) begin
      er = w / 2;
      ec = w % 2;
      wait_valid($sformatf("s6_w%0d", w));
      chk($sformatf("s6_w%0d_row", w), {27'd0, out_row}, 32'(er));
      chk($sformatf("s6_w%0d_col", w), {27'd0, out_col}, 32'(ec));
      chk($sformatf("s6_w%0d_p0", w), 32'(win_out[0]),
          32'(er * 6 + ec));
      chk($sformatf("s6_w%0d_p24", w), 32'(win_out[24]),
          32'((er + 4) * 6 + ec + 4));
      if (w < 3) begin
        tick();
        chk($sformatf("s6_w%0d_done", w), {31'd0, done}, 0);
      end else begin
        tick();
      end
    end
    chk("s6_done", {31'd0, done}, 1);
    chk("s6_err", {31'd0, err}, 0);
    tick();

    // size 32: full-size walk, count windows and cycles
    start(32);
    cyc = 1;
    nwin = 0;
    er = 0;
    ec = 0;
    bad_order = 0;
    f0 = '0;
    f24 = '0;
    for (int t = 0; t < 2000; t++) begin
      if (done) break;
      tick();
      cyc++;
      if (win_valid) begin
        if (out_row != 5'(er) || out_col != 5'(ec)) bad_order++;
        nwin++;
        f0  = 32'(win_out[0]);
        f24 = 32'(win_out[24]);
        if (ec == 27) begin
          ec = 0;
          er++;
        end else begin
          ec++;
        end
      end
    end
    chk("s32_done", {31'd0, done}, 1);
    chk("s32_windows", 32'(nwin), 784);
    chk("s32_order", 32'(bad_order), 0);
    chk("s32_last_p0", f0, 891);
    chk("s32_last_p24", f24, 1023);
    chk("s32_cycles", 32'(cyc + 1), 2 + 2 * 784 + 1);
    tick();

    // backpressure on the second window of size 6
    start(6);
    wait_valid("bp_w0");
    tick();
    wait_valid("bp_w1");
    win_ready = 1'b0;
    unstable = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (!win_valid || out_col != 5'd1 || out_row != 5'd0
          || win_out[0] != 16'sd1 || win_out[24] != 16'sd29)
        unstable++;
    end
    chk("bp_stable", 32'(unstable), 0);
    win_ready = 1'b1;
    tick();
    wait_valid("bp_w2");
    chk("bp_w2_row", {27'd0, out_row}, 1);
    chk("bp_w2_col", {27'd0, out_col}, 0);
    chk("bp_w2_p0", 32'(win_out[0]), 6);
    tick();
    wait_valid("bp_w3");
    chk("bp_w3_col", {27'd0, out_col}, 1);
    chk("bp_w3_p0", 32'(win_out[0]), 7);
    tick();
    chk("bp_done", {31'd0, done}, 1);
    tick();

    // illegal sizes: done+err two cycles after enable
    start(4);
    chk("s4_c1_done", {31'd0, done}, 0);
    tick();
    chk("s4_done", {31'd0, done}, 1);
    chk("s4_err", {31'd0, err}, 1);
    chk("s4_valid", {31'd0, win_valid}, 0);
    tick();
    chk("s4_err_clr", {31'd0, err}, 0);
    start(33);
    chk("s33_c1_valid", {31'd0, win_valid}, 0);
    tick();
    chk("s33_done", {31'd0, done}, 1);
    chk("s33_err", {31'd0, err}, 1);
    tick();
    chk("s33_done_clr", {31'd0, done}, 0);

    // enable during EMIT must not restart or resize the job
    win_ready = 1'b0;
    start(5);
    wait_valid("en_emit");
    size   = 16'd6;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    chk("en_emit_hold", {31'd0, win_valid}, 1);
    tick();
    chk("en_emit_hold2", {31'd0, win_valid}, 1);
    chk("en_emit_p24", 32'(win_out[24]), 24);
    win_ready = 1'b1;
    tick();
    chk("en_emit_done", {31'd0, done}, 1);
    tick();

    // reset during the third window of size 6
    start(6);
    wait_valid("rm_w0");
    tick();
    wait_valid("rm_w1");
    tick();
    wait_valid("rm_w2");
    chk("rm_w2_row", {27'd0, out_row}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_valid", {31'd0, win_valid}, 0);
    chk("rm_done", {31'd0, done}, 0);
    chk("rm_row", {27'd0, out_row}, 0);
    chk("rm_col", {27'd0, out_col}, 0);
    chk("rm_win", {31'd0, win_out == '0}, 1);
    spur = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (done || win_valid || err) spur++;
    end
    chk("rm_no_done", 32'(spur), 0);
    start(5);
    wait_valid("rm_s5");
    chk("rm_s5_p0", 32'(win_out[0]), 0);
    chk("rm_s5_p24", 32'(win_out[24]), 24);
    tick();
    chk("rm_s5_done", {31'd0, done}, 1);
    chk("rm_s5_err", {31'd0, err}, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
